ahb3_lite_n_slave: RTL and testbench

AHB3-Lite memory slave with a 16-bit address bus and a 32-bit data bus. It accepts single and burst transfers from one AHB-Lite master and stores the data in an internal word-organised RAM. Transfers complete with zero wait states, and illegal accesses get the two-cycle ERROR response. The block sits on the system AHB-Lite bus behind the decoder, and a bound protocol-checker monitors HSEL, HADDR, HTRANS and HRESP.

---
 rtl/ahb3_lite_n_slave.sv | 115 +++++++++++
 tb/tb_ahb3_lite_n_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3_lite_n_slave.sv
// AHB3-Lite zero-wait memory slave: 16-bit address, 32-bit data, word-organised RAM
// with byte lanes and a two-cycle ERROR response for illegal transfers.
module ahb3_lite_n_slave #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        i_hclk,
    input  logic        i_hresetn,
    input  logic        i_hsel,
    input  logic [15:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [3:0]  i_hprot,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hreadyout,
    output logic        o_hresp
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [16:0] MEM_BYTES = 17'(4 * MEM_WORDS);

    // ST_ERR2 is the second (ready) ERROR cycle, during which a new address phase may be taken.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_addr;
    logic           r_write;
    logic [2:0]     r_size;
    logic [31:0]    r_mem [MEM_WORDS];

    logic           w_accept;
    logic           w_illegal;
    logic [AW-1:0]  w_word_idx;
    logic [3:0]     w_be;
    logic           w_wr_en;
    logic           w_unused;

    assign w_accept  = i_hsel & i_hready & i_htrans[1] & (r_state != ST_ERR1);
    assign w_illegal = (i_hsize > 3'b010)
                     || ((i_hsize == 3'b001) && i_haddr[0])
                     || ((i_hsize == 3'b010) && (i_haddr[1:0] != 2'b00))
                     || ({1'b0, i_haddr} >= MEM_BYTES);

    always_comb begin
        w_next = ST_IDLE;
        if (r_state == ST_ERR1) begin
            w_next = ST_ERR2;
        end else if (w_accept) begin
            w_next = w_illegal ? ST_ERR1 : ST_DATA;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_addr  <= 16'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else if (w_accept && !w_illegal) begin
            r_addr  <= i_haddr;
            r_write <= i_hwrite;
            r_size  <= i_hsize;
        end
    end

    assign w_word_idx = r_addr[AW+1:2];

    always_comb begin
        w_be = 4'b1111;
        case (r_size[1:0])
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Gating with reset keeps a write whose data phase is cut short by reset from landing.
    assign w_wr_en = (r_state == ST_DATA) & r_write & i_hresetn;

    // RAM contents are intentionally not reset.
    always_ff @(posedge i_hclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= i_hwdata[8*i +: 8];
                end
            end
        end
    end

    // The read is combinational in the data phase, so a write in the preceding data phase
    // has already committed, giving read-after-write without forwarding.
    assign o_hrdata    = ((r_state == ST_DATA) && !r_write) ? r_mem[w_word_idx] : 32'd0;
    assign o_hreadyout = (r_state != ST_ERR1);
    assign o_hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

    assign w_unused = ^{i_hburst, i_hprot, i_htrans[0], r_addr[15:AW+2], r_size[2]};

endmodule

// File: tb/tb_ahb3_lite_n_slave.sv
// Directed bench for ahb3_lite_n_slave: a byte-array memory model plus a per-cycle
// compare process, with literal read-data pins on the key transactions.
module tb_ahb3_lite_n_slave;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = 4 * MEM_WORDS;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    localparam int PH_NONE  = 0;
    localparam int PH_READ  = 1;
    localparam int PH_WRITE = 2;
    localparam int PH_ERR1  = 3;
    localparam int PH_ERR2  = 4;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    int errors = 0;
    int checks = 0;

    logic [7:0]  modelMem [0:MEM_BYTES-1];
    int          mPhase;
    logic [15:0] mAddr;
    logic [2:0]  mSize;

    logic        expReady;
    logic        expResp;
    logic [31:0] expRdata;
    logic        checkEn;

    ahb3_lite_n_slave #(.MEM_WORDS(MEM_WORDS)) dut (
        .i_hclk      (hclk),
        .i_hresetn   (hresetn),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hburst    (hburst),
        .i_hprot     (hprot),
        .i_hwdata    (hwdata),
        .i_hready    (hreadyout),
        .o_hrdata    (hrdata),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isLegal(input logic [2:0] size, input logic [15:0] addr);
        int n;
        if (size > 3'd2) return 1'b0;
        n = 1 << size;
        return ((int'(addr) % n) == 0) && (int'(addr) < MEM_BYTES);
    endfunction

    function automatic logic [31:0] modelWord(input logic [15:0] addr);
        int a;
        a = int'(addr) - (int'(addr) % 4);
        return {modelMem[a+3], modelMem[a+2], modelMem[a+1], modelMem[a]};
    endfunction

    // Expected bus outputs for the data phase the model says is in progress this cycle.
    task automatic setExpect();
        expReady = 1'b1;
        expResp  = 1'b0;
        expRdata = 32'd0;
        case (mPhase)
            PH_READ: expRdata = modelWord(mAddr);
            PH_ERR1: begin expReady = 1'b0; expResp = 1'b1; end
            PH_ERR2: expResp = 1'b1;
            default: ;
        endcase
    endtask

    always @(negedge hclk) begin
        if (checkEn) begin
            checkOutput("hreadyout", {31'd0, hreadyout}, {31'd0, expReady});
            checkOutput("hresp", {31'd0, hresp}, {31'd0, expResp});
            checkOutput("hrdata", hrdata, expRdata);
        end
    end

    // One bus cycle: address phase inputs plus HWDATA for the data phase now in progress.
    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic pinEn,
                                 input logic [31:0] pinVal);
        int n;
        int b;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
        setExpect();
        #3;
        if (pinEn) checkOutput("pinRdata", hrdata, pinVal);
        @(posedge hclk);
        if (!hresetn) begin
            mPhase = PH_NONE;
        end else begin
            if (mPhase == PH_WRITE) begin
                n = 1 << mSize;
                for (int k = 0; k < n; k++) begin
                    b = int'(mAddr) + k;
                    modelMem[b] = wdata[8*(b%4) +: 8];
                end
            end
            if (mPhase == PH_ERR1) begin
                mPhase = PH_ERR2;
            end else if (sel && trans[1]) begin
                if (isLegal(size, addr)) begin
                    mPhase = wr ? PH_WRITE : PH_READ;
                    mAddr  = addr;
                    mSize  = size;
                end else begin
                    mPhase = PH_ERR1;
                end
            end else begin
                mPhase = PH_NONE;
            end
        end
        #1;
    endtask

    // Asserts reset in the middle of the current data phase and checks the outputs react at once.
    task automatic resetMid(input logic [31:0] wdata);
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwdata = wdata;
        setExpect();
        #2;
        hresetn = 1'b0;
        mPhase  = PH_NONE;
        setExpect();
        #1;
        checkOutput("rstReady", {31'd0, hreadyout}, 32'd1);
        checkOutput("rstResp", {31'd0, hresp}, 32'd0);
        checkOutput("rstRdata", hrdata, 32'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
    endtask

    initial begin
        hresetn = 1'b0;
        hsel    = 1'b0;
        haddr   = 16'd0;
        htrans  = T_IDLE;
        hwrite  = 1'b0;
        hsize   = SZ_W;
        hburst  = 3'b000;
        hprot   = 4'b0011;
        hwdata  = 32'd0;
        mPhase  = PH_NONE;
        mAddr   = 16'd0;
        mSize   = SZ_W;
        setExpect();
        checkEn = 1'b1;
        @(posedge hclk);
        #1;
        applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h0, 0, 32'h0);
        applyStimulus(0, T_IDLE, 0, SZ_W, 16'h0000, 32'h0, 0, 32'h0);
        hresetn = 1'b1;

        // Word round-trip
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0010, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0010, 32'hDEADBEEF, 0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'hDEADBEEF);

        // Byte and halfword lanes
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0020, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 1, SZ_B, 16'h0021, 32'h00000000, 0, 32'h0);
        applyStimulus(1, T_NONSEQ, 1, SZ_H, 16'h0022, 32'hFFFFAAFF, 0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0020, 32'h1234FFFF, 0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'h1234AA00);

        // Pipelined read-after-write
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0030, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0030, 32'h0000CAFE, 0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'h0000CAFE);

        // INCR4 write burst with a BUSY beat, then burst read-back
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0040, 32'h0,        0, 32'h0);
        applyStimulus(1, T_SEQ,    1, SZ_W, 16'h0044, 32'd1,        0, 32'h0);
        applyStimulus(1, T_BUSY,   1, SZ_W, 16'h0048, 32'd2,        0, 32'h0);
        applyStimulus(1, T_SEQ,    1, SZ_W, 16'h0048, 32'hFFFFFFFF, 0, 32'h0);
        applyStimulus(1, T_SEQ,    1, SZ_W, 16'h004C, 32'd3,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0040, 32'd4,        0, 32'h0);
        applyStimulus(1, T_SEQ,    0, SZ_W, 16'h0044, 32'h0,        1, 32'd1);
        applyStimulus(1, T_SEQ,    0, SZ_W, 16'h0048, 32'h0,        1, 32'd2);
        applyStimulus(1, T_SEQ,    0, SZ_W, 16'h004C, 32'h0,        1, 32'd3);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'd4);

        // Misaligned read, with a write offered during ERR1 that must be ignored
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0002, 32'h5A5A5A5A, 0, 32'h0);
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h77777777, 0, 32'h0);

        // Out-of-range write aliasing word 0 must not land; oversize transfer errors
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h1000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'hBADBAD00, 0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'hBADBAD00, 0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, 3'b011, 16'h0000, 32'h0,      1, 32'h5A5A5A5A);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        0, 32'h0);

        // Unselected write and IDLE with write set leave memory alone
        applyStimulus(0, T_NONSEQ, 1, SZ_W, 16'h0010, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   1, SZ_W, 16'h0010, 32'h0BADF00D, 0, 32'h0);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0010, 32'h0BADF00D, 0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'hDEADBEEF);

        // Reset in the middle of a write data phase drops the write
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0050, 32'h0,        0, 32'h0);
        applyStimulus(1, T_NONSEQ, 1, SZ_W, 16'h0050, 32'h11111111, 0, 32'h0);
        resetMid(32'h22222222);
        applyStimulus(1, T_NONSEQ, 0, SZ_W, 16'h0050, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        1, 32'h11111111);

        // Reset during ERR1 releases HREADYOUT immediately
        applyStimulus(1, T_NONSEQ, 0, SZ_H, 16'h0001, 32'h0,        0, 32'h0);
        resetMid(32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        0, 32'h0);
        applyStimulus(1, T_IDLE,   0, SZ_W, 16'h0000, 32'h0,        0, 32'h0);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
